// File: rtl/sens_data_pkg.sv
// sens_data_pkg: shared constants, FSM state enum and BRAM address helper for the ToF sensor frame path.
package sens_data_pkg;
  localparam int N_SENS  = 8;
  localparam int N_ZONES = 64;
  localparam int ADDR_W  = 9;
  typedef enum logic {COLLECT, FULL} state_t;
  function automatic logic [ADDR_W-1:0] mk_addr(input logic [2:0] sens, input logic [5:0] zone);
    return {sens, zone};
  endfunction
endpackage

// File: rtl/sens_frame_tracker.sv
// sens_frame_tracker: zone counter, sensor latch, frame length/sensor switch checks and per-sensor complete mask.
module sens_frame_tracker
  import sens_data_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hs,
  input  logic              clr,
  input  logic [2:0]        s_sens_id,
  input  logic              s_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              err,
  output logic [N_SENS-1:0] sens_mask
);
  logic [5:0] z;
  logic [2:0] cur_sens, sens;
  logic       sw_err, at_end;
  always_comb begin
    sens    = z == 6'd0 ? s_sens_id : cur_sens;
    sw_err  = z != 6'd0 && s_sens_id != cur_sens;
    at_end  = z == 6'(N_ZONES - 1);
    wr_en   = hs && !sw_err;
    wr_addr = mk_addr(sens, z);
    err     = hs && (sw_err || s_last != at_end);
  end
  // Any frame end, good or bad, and any dropped beat restart the zone count.
  always_ff @(posedge clk)
    if (rst) begin
      z         <= '0;
      cur_sens  <= '0;
      sens_mask <= '0;
    end else begin
      if (hs) begin
        z <= (sw_err || s_last || at_end) ? 6'd0 : z + 6'd1;
        if (z == 6'd0) cur_sens <= s_sens_id;
      end
      if (clr) sens_mask <= '0;
      else if (hs && !sw_err && s_last && at_end) sens_mask[sens] <= 1'b1;
    end
endmodule

// File: rtl/sens_data_writer.sv
// sens_data_writer: writes 8x64-zone ToF frames into BRAM and flags a complete frame set until the reader consumes it.
module sens_data_writer
  import sens_data_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_SENS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [2:0]        s_sens_id,
  input  logic              s_last,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              drdy,
  input  logic              consumed,
  output logic [N_SENS-1:0] sens_mask,
  output logic              err_len
);
  state_t            state, state_nxt;
  logic              hs, clr, wr_en, err;
  logic [ADDR_W-1:0] wr_addr;
  always_comb begin
    s_ready   = state == COLLECT;
    drdy      = state == FULL;
    hs        = s_valid && s_ready;
    clr       = drdy && consumed;
    state_nxt = s_ready ? (&sens_mask ? FULL : COLLECT) : (consumed ? COLLECT : FULL);
  end
  sens_frame_tracker u_trk (
    .clk       (clk),
    .rst       (rst),
    .hs        (hs),
    .clr       (clr),
    .s_sens_id (s_sens_id),
    .s_last    (s_last),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .err       (err),
    .sens_mask (sens_mask)
  );
  // Write port is one register stage behind the handshake.
  always_ff @(posedge clk)
    if (rst) begin
      state      <= COLLECT;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      err_len    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bram_we <= wr_en;
      err_len <= err;
      if (wr_en) begin
        bram_addr  <= wr_addr;
        bram_wdata <= s_data;
      end
    end
endmodule

// File: doc/sens_data_writer.md
SENS_DATA_WRITER -- requirements
Module: sens_data_writer

Interface
REQ-001 Parameter DATA_W, default 16, width of one zone distance sample.
REQ-002 Parameter N_SENS, default 8, number of ToF sensors per frame set; fixed at 8 for the 9-bit address map.
REQ-003 clk  in  1  rising-edge clock for all logic.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 s_valid  in  1  input sample valid.
REQ-006 s_ready  out  1  block accepts a sample this cycle.
REQ-007 s_data  in  DATA_W  zone sample.
REQ-008 s_sens_id  in  3  source sensor of the current sample.
REQ-009 s_last  in  1  marks zone 63, the final sample of a sensor frame.
REQ-010 bram_we  out  1  BRAM write strobe.
REQ-011 bram_addr  out  9  BRAM address {sens[2:0], row[2:0], col[2:0]}.
REQ-012 bram_wdata  out  DATA_W  BRAM write data.
REQ-013 drdy  out  1  complete frame set present in BRAM (level).
REQ-014 consumed  in  1  single-cycle pulse from the reader: frame set read out.
REQ-015 sens_mask  out  8  per-sensor frame-complete flags.
REQ-016 err_len  out  1  single-cycle pulse on a frame-length or sensor-switch error.

Function
REQ-017 A handshake occurs when s_valid && s_ready are both high.
REQ-018 Internal 6-bit zone counter z: row = z[5:3], col = z[2:0]. z increments per handshake and wraps to 0 after a frame ends or an error.
REQ-019 s_sens_id is latched as cur_sens on the handshake with z == 0. Later beats of that frame use cur_sens.
REQ-020 Each handshake produces bram_we = 1 exactly one cycle later, with bram_addr = {cur_sens, z} and bram_wdata = the s_data captured at the handshake. bram_we = 0 in all other cycles.
REQ-021 Handshake with s_last = 1 and z == 63: write the sample, set sens_mask[cur_sens], reset z to 0.
REQ-022 Early s_last (z < 63): write the sample, pulse err_len, reset z to 0, leave sens_mask unchanged.
REQ-023 Late s_last (z == 63 and s_last = 0): write the sample, pulse err_len, reset z to 0, leave sens_mask unchanged.
REQ-024 s_sens_id differs from cur_sens on a beat with z != 0: drop the beat (no write), pulse err_len, reset z to 0.
REQ-025 A repeated frame from a sensor whose mask bit is already set overwrites its BRAM region; the mask bit stays set.
REQ-026 State machine, states COLLECT and FULL.
 - COLLECT: s_ready = 1, drdy = 0.
 - COLLECT -> FULL in the cycle after sens_mask becomes 8'hFF.
REQ-027 FULL: s_ready = 0, drdy = 1, no BRAM writes.
 - FULL -> COLLECT on consumed = 1; sens_mask clears to 0 in the same edge.
REQ-028 consumed is ignored while in COLLECT.
REQ-029 A pending write from the last handshake completes on the cycle FULL is entered.

Reset
REQ-030 On rst = 1 at a clock edge:
 - state = COLLECT, z = 0, cur_sens = 0, sens_mask = 0.
 - bram_we = 0, bram_addr = 0, bram_wdata = 0, drdy = 0, err_len = 0.
 - s_ready = 1 from the first cycle after reset.
REQ-031 rst asserted mid-frame discards the partial frame. BRAM contents are not cleared.

Structure
REQ-032 Shared package sens_data_pkg holds:
 - constants N_SENS = 8, N_ZONES = 64, ADDR_W = 9;
 - the state enum {COLLECT, FULL};
 - the address concatenation helper.
 The reader FSM also imports this package.
REQ-033 One sub-module, sens_frame_tracker, is natural: zone counter, cur_sens latch, length/switch error checks, and sens_mask.

Verification
REQ-034 Eight well-formed 64-beat frames, sensors 0..7, s_valid held high -> 512 writes to addresses 0..511 in order; drdy = 1 two cycles after the final handshake; s_ready = 0.
REQ-035 In FULL, drive s_valid = 1 for 10 cycles, then pulse consumed -> no writes during FULL; one cycle after consumed, drdy = 0, sens_mask = 0, s_ready = 1.
REQ-036 Sensor 3 frame with s_last on beat 40 -> err_len pulses once; sens_mask[3] = 0; next beat writes address {3'd?, 6'd0} using the new s_sens_id.
REQ-037 Sensor 5 frame whose s_sens_id changes to 6 at beat 10 -> no write for that beat; err_len pulses; z = 0.
REQ-038 rst asserted at beat 30 of sensor 2 -> all outputs at reset values next cycle; a fresh sensor 2 frame starts at address 0x080.
REQ-039 Random s_valid gaps, sensor order 7..0 -> drdy asserts only after all eight frames; data at each {sens, row, col} matches the sent sample.
